mdu_seq: RTL

- Multi-cycle multiply/divide unit beside the 32-bit ALU in the MIPS datapath.
- Executes MULT, MULTU, DIV and DIVU iteratively, one iteration per clock, and writes the 64-bit result into architectural HI/LO registers.
- Consumes the 32-bit adder built from the team's 1-bit ALU slices: aluop 3'b010 = add, aluop 3'b110 = subtract, carry-out from the MSB slice.
- Gives the pipeline a start/busy/done handshake so stall logic can hold off HI/LO readers.

---
 rtl/mdu_pkg.sv | 37 +++
 rtl/mdu_seq_alu32.sv | 53 +++++
 rtl/mdu_seq.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the multi-cycle multiply/divide unit:
//   - operation encodings as seen on the mdu_seq op port
//   - FSM state encoding of the sequencer
//   - operation codes understood by the shared alu32 adder
//   - small decode helpers for the operation field
// ---------------------------------------------------------------------------
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_MULT  = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_DIV   = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FIXUP = 2'b10
    } mdu_state_e;

    localparam logic [2:0] ALUOP_ADD = 3'b010;
    localparam logic [2:0] ALUOP_SUB = 3'b110;

    // Bit 1 of the encoding separates the divide family from the multiply family
    function automatic logic isDivide(input mdu_op_e opCode);
        return opCode[1];
    endfunction

    // Bit 0 of the encoding marks the signed variants (MULT, DIV)
    function automatic logic isSignedOp(input mdu_op_e opCode);
        return opCode[0];
    endfunction

endpackage

// File: rtl/mdu_seq_alu32.sv
// ---------------------------------------------------------------------------
// alu32
// Ripple-carry ALU built from 1-bit slices, shared by the datapath and the
// multiply/divide unit.
//   i_a, i_b   : operands
//   i_aluop    : [2] = invert B and carry-in (subtract), [1:0] = function
//                00 AND, 01 OR, 10 ADD/SUB, 11 set-less-than
//   o_result   : selected function result
//   o_cout     : carry out of the MSB slice (for subtract: 1 means no borrow)
// ---------------------------------------------------------------------------
module alu32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_aluop,
    output logic [WIDTH-1:0] o_result,
    output logic             o_cout
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_bInv;
    logic             w_carryOut;

    // Each iteration is one 1-bit slice; the carry variable threads the
    // slices together so the ripple chain stays inside a single process.
    always_comb begin : p_ripple
        logic c;
        w_sum  = '0;
        w_bInv = '0;
        c      = i_aluop[2];
        for (int i = 0; i < WIDTH; i++) begin
            w_bInv[i] = i_b[i] ^ i_aluop[2];
            w_sum[i]  = i_a[i] ^ w_bInv[i] ^ c;
            c         = (i_a[i] & w_bInv[i]) | (i_a[i] & c) | (w_bInv[i] & c);
        end
        w_carryOut = c;
    end

    // Function select; set-less-than uses the sign of the difference
    always_comb begin
        o_result = '0;
        case (i_aluop[1:0])
            2'b00:   o_result = i_a & w_bInv;
            2'b01:   o_result = i_a | w_bInv;
            2'b10:   o_result = w_sum;
            default: o_result = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1]};
        endcase
    end

    assign o_cout = w_carryOut;

endmodule

// File: rtl/mdu_seq.sv
// ---------------------------------------------------------------------------
// mdu_seq
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use shift-and-add, DIV/DIVU use restoring division; both run
// one iteration per clock on magnitudes, and signs are applied in a final
// FIXUP cycle.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, op, a, b   : launch request, operation and operands (idle only)
//   hi_we, lo_we      : MTHI / MTLO write enables (idle only), data on wdata
//   busy              : operation in progress
//   done              : one-cycle pulse when HI/LO hold a new result
//   dz                : last completed op was a divide by zero
//   hi, lo            : HI / LO registers
// ---------------------------------------------------------------------------
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

    mdu_state_e       r_state;
    mdu_op_e          r_op;
    logic [CNT_W-1:0] r_count;
    logic             r_signQ;
    logic             r_signR;
    logic             r_bZero;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_hiPart;
    logic [WIDTH-1:0] r_loPart;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;
    logic             r_dz;

    mdu_op_e          w_startOp;
    logic             w_startSigned;
    logic             w_startDiv;
    logic [WIDTH-1:0] w_aMag;
    logic [WIDTH-1:0] w_bMag;

    logic [WIDTH-1:0] w_aluA;
    logic [WIDTH-1:0] w_aluB;
    logic [2:0]       w_aluOp;
    logic [WIDTH-1:0] w_aluY;
    logic             w_aluCout;

    logic [WIDTH:0]   w_mulAcc;
    logic [WIDTH-1:0] w_divShift;
    logic             w_divOk;
    logic [WIDTH-1:0] w_divR;
    logic [WIDTH-1:0] w_divQ;

    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prodNeg;
    logic [WIDTH-1:0]   w_qNeg;
    logic [WIDTH-1:0]   w_rNeg;

    // Operand decode at launch: signed ops iterate on magnitudes so a single
    // unsigned datapath serves all four operations.
    assign w_startOp     = mdu_op_e'(op);
    assign w_startSigned = isSignedOp(w_startOp);
    assign w_startDiv    = isDivide(w_startOp);
    assign w_aMag        = (w_startSigned && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign w_bMag        = (w_startSigned && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

    // The shared adder adds the multiplicand to P_hi when multiplying and
    // subtracts the divisor from the left-shifted remainder when dividing.
    always_comb begin
        w_aluB = r_mcand;
        if (isDivide(r_op)) begin
            w_aluA  = w_divShift;
            w_aluOp = ALUOP_SUB;
        end else begin
            w_aluA  = r_hiPart;
            w_aluOp = ALUOP_ADD;
        end
    end

    alu32 #(
        .WIDTH(WIDTH)
    ) u_alu (
        .i_a      (w_aluA),
        .i_b      (w_aluB),
        .i_aluop  (w_aluOp),
        .o_result (w_aluY),
        .o_cout   (w_aluCout)
    );

    // Multiply step: the adder carry becomes bit WIDTH of the accumulator
    assign w_mulAcc = r_loPart[0] ? {w_aluCout, w_aluY} : {1'b0, r_hiPart};

    // Divide step: the bit shifted out of R is kept implicitly. When it is
    // set the shifted remainder exceeds any divisor, so the subtraction
    // always succeeds and the truncated difference is still exact.
    assign w_divShift = {r_hiPart[WIDTH-2:0], r_loPart[WIDTH-1]};
    assign w_divOk    = w_aluCout | r_hiPart[WIDTH-1];
    assign w_divR     = w_divOk ? w_aluY : w_divShift;
    assign w_divQ     = {r_loPart[WIDTH-2:0], w_divOk};

    // Sign restoration uses plain incrementers, independent of the adder
    assign w_prod    = {r_hiPart, r_loPart};
    assign w_prodNeg = ~w_prod + (2*WIDTH)'(1);
    assign w_qNeg    = ~r_loPart + WIDTH'(1);
    assign w_rNeg    = ~r_hiPart + WIDTH'(1);

    // Sequencer: IDLE accepts a launch and MTHI/MTLO writes, RUN performs
    // ITER iterations, FIXUP applies signs and commits HI/LO. All outputs
    // are registered here; done is cleared every edge unless FIXUP sets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_op     <= MDU_MULTU;
            r_count  <= '0;
            r_signQ  <= 1'b0;
            r_signR  <= 1'b0;
            r_bZero  <= 1'b0;
            r_mcand  <= '0;
            r_hiPart <= '0;
            r_loPart <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (hi_we) begin
                        r_hi <= wdata;
                    end
                    if (lo_we) begin
                        r_lo <= wdata;
                    end
                    if (start) begin
                        r_op     <= w_startOp;
                        r_signQ  <= w_startSigned & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_signR  <= w_startSigned & a[WIDTH-1];
                        r_bZero  <= (b == '0);
                        r_mcand  <= w_startDiv ? w_bMag : w_aMag;
                        r_loPart <= w_startDiv ? w_aMag : w_bMag;
                        r_hiPart <= '0;
                        r_count  <= '0;
                        r_dz     <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (isDivide(r_op)) begin
                        r_hiPart <= w_divR;
                        r_loPart <= w_divQ;
                    end else begin
                        r_hiPart <= w_mulAcc[WIDTH:1];
                        r_loPart <= {w_mulAcc[0], r_loPart[WIDTH-1:1]};
                    end
                    if (r_count == LAST_ITER) begin
                        r_state <= ST_FIXUP;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end

                ST_FIXUP: begin
                    case (r_op)
                        MDU_MULT: begin
                            {r_hi, r_lo} <= r_signQ ? w_prodNeg : w_prod;
                        end
                        MDU_DIV: begin
                            r_lo <= r_signQ ? w_qNeg : r_loPart;
                            r_hi <= r_signR ? w_rNeg : r_hiPart;
                        end
                        MDU_DIVU: begin
                            r_lo <= r_loPart;
                            r_hi <= r_hiPart;
                        end
                        default: begin
                            {r_hi, r_lo} <= w_prod;
                        end
                    endcase
                    r_dz    <= isDivide(r_op) & r_bZero;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign dz   = r_dz;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
